au_sat_div: RTL and testbench

//  Parametrised sign-magnitude fixed-point arithmetic unit for the Kalman datapath.

---
 rtl/au_pkg.sv | 48 ++++
 rtl/au_div_seq.sv | 61 ++++++
 rtl/au_sat_div.sv | 171 +++++++++++++++++
 tb/tb_au_sat_div.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/au_pkg.sv
// ---------------------------------------------------------------------------
// au_pkg : shared codes, FSM states and sign-magnitude helpers for au_sat_div
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package au_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MULT = 2'b10,
        OP_DIV  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        MY_S     = 2'b00,
        MY_IMM   = 2'b01,
        MY_SQR   = 2'b10,
        MY_S_ALT = 2'b11
    } mul_y_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } state_e;

    // Helpers work on a wide container; callers size-cast the result down.
    localparam int unsigned SM_MAXW = 64;

    function automatic logic [SM_MAXW-1:0] sat_mag(input int unsigned w);
        return (SM_MAXW'(1) << (w - 1)) - SM_MAXW'(1);
    endfunction

    function automatic logic sm_zero(input logic [SM_MAXW-1:0] v, input int unsigned w);
        return (v & sat_mag(w)) == '0;
    endfunction

    // A zero magnitude always packs as +0.
    function automatic logic [SM_MAXW-1:0] sm_pack(input logic s,
                                                   input logic [SM_MAXW-1:0] mag,
                                                   input int unsigned w);
        return (mag & sat_mag(w)) | (SM_MAXW'(s & (mag != '0)) << (w - 1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/au_div_seq.sv
// ---------------------------------------------------------------------------
// au_div_seq : magnitude-only restoring divider, one quotient bit per step
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module au_div_seq #(
    parameter int DW = 37,
    parameter int VW = 23
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          done,
    output logic [DW-1:0] quo_nxt,
    output logic          half
);

    localparam int CW = $clog2(DW);

    logic [CW-1:0] r_cnt;
    logic [VW-1:0] r_rem;
    logic [DW-1:0] r_quo;
    logic [VW-1:0] r_div;

    logic [VW:0] w_shift;
    logic        w_ge;
    logic [VW:0] w_rem_nxt;

    assign w_shift   = {r_rem, r_quo[DW-1]};
    assign w_ge      = w_shift >= {1'b0, r_div};
    assign w_rem_nxt = w_ge ? (w_shift - {1'b0, r_div}) : w_shift;
    assign quo_nxt   = {r_quo[DW-2:0], w_ge};
    // Round half-up: the discarded fraction is at least one half of the divisor.
    assign half      = {w_rem_nxt, 1'b0} >= {2'b00, r_div};
    assign done      = step && (r_cnt == CW'(DW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
        end else if (load) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= dividend;
            r_div <= divisor;
        end else if (step) begin
            r_cnt <= r_cnt + CW'(1);
            r_rem <= w_rem_nxt[VW-1:0];
            r_quo <= quo_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/au_sat_div.sv
// ---------------------------------------------------------------------------
// au_sat_div : sign-magnitude fixed-point ADD/SUB/MULT with saturation, iterative DIV
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module au_sat_div
    import au_pkg::*;
#(
    parameter int W     = 24,
    parameter int FRAC  = 14,
    parameter int ROUND = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] R_in,
    input  logic [W-1:0] S_in,
    input  logic [W-1:0] Iimm_in,
    input  logic [1:0]   op_sel,
    input  logic [1:0]   mul_y_sel,
    output logic [W-1:0] result,
    output logic         done,
    output logic         busy,
    output logic         ovf,
    output logic         dz
);

    localparam int MW = W - 1;
    localparam int K  = MW + FRAC;
    localparam logic [MW-1:0]   c_max    = MW'(sat_mag(W));
    localparam logic [2*MW:0]   c_mround = (ROUND != 0) ? ((2*MW+1)'(1) << (FRAC - 1)) : '0;

    state_e r_state, w_state_nxt;
    logic [W-1:0] r_result;
    logic         r_done, r_ovf, r_dz, r_qsign;

    op_e          w_op;
    logic         w_sx, w_sy, w_ydz, w_accept, w_div_load;
    logic [MW-1:0] w_mx, w_my;
    logic [W-1:0] w_mul_y;
    logic signed [W:0] w_ax, w_ay, w_sum;
    logic [W:0]   w_sum_abs;
    logic [2*MW-1:0] w_prod;
    logic [2*MW:0]   w_mq;
    logic         w_div_done, w_half;
    logic [K-1:0] w_quo_nxt;
    logic [K:0]   w_dq;
    logic         w_sign1, w_ovf1, w_dz1;
    logic [MW-1:0] w_mag1;
    logic [W-1:0] w_res1, w_div_res;

    assign w_op       = op_e'(op_sel);
    assign w_sx       = R_in[W-1];
    assign w_sy       = S_in[W-1];
    assign w_mx       = R_in[MW-1:0];
    assign w_my       = S_in[MW-1:0];
    assign w_ydz      = sm_zero(SM_MAXW'(S_in), W);
    assign w_accept   = start && (r_state == ST_IDLE);
    assign w_div_load = w_accept && (w_op == OP_DIV) && !w_ydz;

    always_comb begin
        w_mul_y = S_in;
        case (mul_y_e'(mul_y_sel))
            MY_IMM:  w_mul_y = Iimm_in;
            MY_SQR:  w_mul_y = R_in;
            default: w_mul_y = S_in;
        endcase
    end

    // Subtraction folds into addition by flipping the sign of Y.
    assign w_ax      = w_sx ? -$signed({2'b00, w_mx}) : $signed({2'b00, w_mx});
    assign w_ay      = (w_sy ^ (w_op == OP_SUB)) ? -$signed({2'b00, w_my}) : $signed({2'b00, w_my});
    assign w_sum     = w_ax + w_ay;
    assign w_sum_abs = w_sum[W] ? $unsigned(-w_sum) : $unsigned(w_sum);

    assign w_prod = (2*MW)'(w_mx) * (2*MW)'(w_mul_y[MW-1:0]);
    assign w_mq   = ({1'b0, w_prod} + c_mround) >> FRAC;

    always_comb begin
        w_sign1 = 1'b0;
        w_mag1  = '0;
        w_ovf1  = 1'b0;
        w_dz1   = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB: begin
                w_sign1 = w_sum[W];
                w_ovf1  = w_sum_abs > {2'b00, c_max};
                w_mag1  = w_ovf1 ? c_max : w_sum_abs[MW-1:0];
            end
            OP_MULT: begin
                w_sign1 = w_sx ^ w_mul_y[W-1];
                w_ovf1  = w_mq > (2*MW+1)'(c_max);
                w_mag1  = w_ovf1 ? c_max : w_mq[MW-1:0];
            end
            default: begin
                w_sign1 = w_sx ^ w_sy;
                w_mag1  = c_max;
                w_ovf1  = 1'b1;
                w_dz1   = 1'b1;
            end
        endcase
    end

    assign w_res1 = W'(sm_pack(w_sign1, SM_MAXW'(w_mag1), W));

    au_div_seq #(
        .DW (K),
        .VW (MW)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_div_load),
        .step     (r_state == ST_DIV),
        .dividend ({w_mx, {FRAC{1'b0}}}),
        .divisor  (w_my),
        .done     (w_div_done),
        .quo_nxt  (w_quo_nxt),
        .half     (w_half)
    );

    assign w_dq      = {1'b0, w_quo_nxt} + (K+1)'((ROUND != 0) && w_half);
    assign w_div_res = (w_dq > (K+1)'(c_max))
                     ? W'(sm_pack(r_qsign, SM_MAXW'(c_max), W))
                     : W'(sm_pack(r_qsign, SM_MAXW'(w_dq[MW-1:0]), W));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_div_load) w_state_nxt = ST_DIV;
            ST_DIV:  if (w_div_done) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_dz     <= 1'b0;
            r_qsign  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            if (w_div_load) begin
                r_qsign <= w_sx ^ w_sy;
            end else if (w_accept) begin
                r_result <= w_res1;
                r_ovf    <= w_ovf1;
                r_dz     <= w_dz1;
                r_done   <= 1'b1;
            end else if (w_div_done) begin
                r_result <= w_div_res;
                r_ovf    <= w_dq > (K+1)'(c_max);
                r_dz     <= 1'b0;
                r_done   <= 1'b1;
            end
        end
    end

    assign result = r_result;
    assign done   = r_done;
    assign busy   = (r_state == ST_DIV);
    assign ovf    = r_ovf;
    assign dz     = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_au_sat_div.sv
// ---------------------------------------------------------------------------
// tb_au_sat_div : directed self-checking bench for au_sat_div (truncating and rounding)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_au_sat_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] R_in = '0, S_in = '0, Iimm_in = '0;
    logic [1:0]  op_sel = '0, mul_y_sel = '0;

    logic [23:0] result, result_r;
    logic        done, busy, ovf, dz;
    logic        done_r, busy_r, ovf_r, dz_r;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    au_sat_div #(.W(24), .FRAC(14), .ROUND(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .R_in(R_in), .S_in(S_in),
        .Iimm_in(Iimm_in), .op_sel(op_sel), .mul_y_sel(mul_y_sel),
        .result(result), .done(done), .busy(busy), .ovf(ovf), .dz(dz)
    );

    au_sat_div #(.W(24), .FRAC(14), .ROUND(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .start(start), .R_in(R_in), .S_in(S_in),
        .Iimm_in(Iimm_in), .op_sel(op_sel), .mul_y_sel(mul_y_sel),
        .result(result_r), .done(done_r), .busy(busy_r), .ovf(ovf_r), .dz(dz_r)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Integer value to S9.14 sign-magnitude, zero encoded as +0.
    function automatic logic [23:0] enc(input int v);
        logic [22:0] m;
        m = 23'((v < 0 ? -v : v) << 14);
        return {(v < 0), m};
    endfunction

    task automatic issue(input logic [1:0] op, input logic [1:0] mys,
                         input logic [23:0] r, input logic [23:0] s, input logic [23:0] imm);
        @(negedge clk);
        op_sel = op; mul_y_sel = mys; R_in = r; S_in = s; Iimm_in = imm;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges = k;
                break;
            end
        end
    endtask

    initial begin
        int busy_cnt, done_edge, edges;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_dz", 32'(dz), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD saturation
        issue(2'b00, 2'b00, 24'h4B0000, 24'h4B0000, 24'h0);
        chk("add_sat_done", 32'(done), 32'h1);
        chk("add_sat_res", 32'(result), 32'h7FFFFF);
        chk("add_sat_ovf", 32'(ovf), 32'h1);
        chk("add_sat_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        chk("add_done_pulse", 32'(done), 32'h0);
        chk("add_res_hold", 32'(result), 32'h7FFFFF);

        // SUB to zero, and -0 + -0
        issue(2'b01, 2'b00, 24'h008000, 24'h008000, 24'h0);
        chk("sub_zero_res", 32'(result), 32'h0);
        chk("sub_zero_ovf", 32'(ovf), 32'h0);
        issue(2'b00, 2'b00, 24'h800000, 24'h800000, 24'h0);
        chk("add_negzero", 32'(result), 32'h0);

        // MULT with immediate source
        issue(2'b10, 2'b01, 24'h006000, 24'h00C000, 24'h008000);
        chk("mul_imm_res", 32'(result), 32'h00C000);
        chk("mul_imm_ovf", 32'(ovf), 32'h0);
        // MULT square of -3.0
        issue(2'b10, 2'b10, 24'h80C000, 24'h004000, 24'h004000);
        chk("mul_sqr_res", 32'(result), 32'h024000);
        // MULT LSB handling
        issue(2'b10, 2'b00, 24'h000001, 24'h002000, 24'h0);
        chk("mul_trunc", 32'(result), 32'h000000);
        chk("mul_round", 32'(result_r), 32'h000001);
        // MULT saturation 256*256, negative
        issue(2'b10, 2'b00, 24'h400000, 24'hC00000, 24'h0);
        chk("mul_sat_res", 32'(result), 32'hFFFFFF);
        chk("mul_sat_ovf", 32'(ovf), 32'h1);

        // DIV -7.0 / 2.0 with an ignored start at E5
        issue(2'b11, 2'b00, 24'h81C000, 24'h008000, 24'h0);
        chk("div_busy_e0", 32'(busy), 32'h1);
        chk("div_done_e0", 32'(done), 32'h0);
        busy_cnt = 1;
        done_edge = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 5) begin
                op_sel = 2'b00; R_in = 24'h004000; S_in = 24'h004000; start = 1'b1;
            end else begin
                start = 1'b0; R_in = 24'h123456; S_in = 24'h000001;
            end
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done && busy) chk("div_done_with_busy", 32'({done, busy}), 32'h0);
            if (done) begin
                done_edge = k;
                break;
            end
        end
        start = 1'b0;
        chk("div_done_edge", 32'(done_edge), 32'd37);
        chk("div_busy_cycles", 32'(busy_cnt), 32'd37);
        chk("div_res", 32'(result), 32'h80E000);
        chk("div_res_round", 32'(result_r), 32'h80E000);
        chk("div_ovf", 32'(ovf), 32'h0);
        chk("div_dz", 32'(dz), 32'h0);
        @(posedge clk); #1;
        chk("div_done_pulse", 32'(done), 32'h0);
        chk("div_res_hold", 32'(result), 32'h80E000);

        // DIV rounding: 2.0 / 3.0
        issue(2'b11, 2'b00, 24'h008000, 24'h00C000, 24'h0);
        wait_done(edges);
        chk("div23_edge", 32'(edges), 32'd37);
        chk("div23_trunc", 32'(result), 32'h002AAA);
        chk("div23_round", 32'(result_r), 32'h002AAB);

        // DIV saturation: 256.0 / tiny
        issue(2'b11, 2'b00, 24'h400000, 24'h000001, 24'h0);
        wait_done(edges);
        chk("divsat_res", 32'(result), 32'h7FFFFF);
        chk("divsat_ovf", 32'(ovf), 32'h1);

        // DIV by -0
        issue(2'b11, 2'b00, 24'h004000, 24'h800000, 24'h0);
        chk("dz_done", 32'(done), 32'h1);
        chk("dz_busy", 32'(busy), 32'h0);
        chk("dz_res", 32'(result), 32'hFFFFFF);
        chk("dz_flag", 32'(dz), 32'h1);
        chk("dz_ovf", 32'(ovf), 32'h1);
        @(posedge clk); #1;
        chk("dz_busy_after", 32'(busy), 32'h0);

        // Reset during a DIV
        issue(2'b11, 2'b00, 24'h81C000, 24'h008000, 24'h0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_res", 32'(result), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_flags", 32'({done, ovf, dz}), 32'h0);
        done_edge = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (done) done_edge++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || busy) done_edge++;
        end
        chk("mid_rst_no_done", 32'(done_edge), 32'h0);
        issue(2'b00, 2'b00, 24'h004000, 24'h004000, 24'h0);
        chk("post_rst_add", 32'(result), 32'h008000);

        // Integer sweep for ADD/SUB/MULT
        for (int i = -4; i <= 4; i++) begin
            for (int j = -4; j <= 4; j++) begin
                issue(2'b00, 2'b00, enc(i), enc(j), 24'h0);
                chk($sformatf("sweep_add_%0d_%0d", i, j), 32'(result), 32'(enc(i + j)));
                issue(2'b01, 2'b00, enc(i), enc(j), 24'h0);
                chk($sformatf("sweep_sub_%0d_%0d", i, j), 32'(result), 32'(enc(i - j)));
                issue(2'b10, 2'b11, enc(i), enc(j), 24'h0);
                chk($sformatf("sweep_mul_%0d_%0d", i, j), 32'(result), 32'(enc(i * j)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
